// File: rtl/onehot_finish_detector_pkg.sv
// Shared types and helpers for the one-hot finish detector.
package onehot_finish_detector_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int STB_W = 4;

    function automatic int idx_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/onehot_finish_detector_onehot_classify.sv
// Combinational zero / one-hot / multi classifier with bit-position encoder.
module onehot_classify
    import onehot_finish_detector_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int IDX_W = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic             is_zero,
    output logic             is_onehot,
    output logic             is_multi,
    output logic [IDX_W-1:0] index
);

    logic w_found;

    assign is_zero   = (i_vec == '0);
    assign is_multi  = ((i_vec & (i_vec - WIDTH'(1))) != '0);
    assign is_onehot = !is_zero && !is_multi;

    // Lowest set bit; only meaningful when is_onehot is high.
    always_comb begin
        index   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i_vec[i] && !w_found) begin
                index   = IDX_W'(i);
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/onehot_finish_detector.sv
// Watches a qualified vector and finishes once the same one-hot index
// has been seen STABLE consecutive valid samples in a row.
module onehot_finish_detector
    import onehot_finish_detector_pkg::*;
#(
    parameter  int WIDTH  = 4,
    parameter  int STABLE = 2,
    parameter  int CNT_W  = 16,
    localparam int IDX_W  = idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             is_finished,
    output logic [IDX_W-1:0] idx,
    output logic             err_zero,
    output logic             err_multi,
    output logic [CNT_W-1:0] samples
);

    state_t             r_state,     w_state_nxt;
    logic               r_busy,      w_busy_nxt;
    logic               r_fin,       w_fin_nxt;
    logic [IDX_W-1:0]   r_idx,       w_idx_nxt;
    logic [IDX_W-1:0]   r_prev_idx,  w_prev_idx_nxt;
    logic               r_err_zero,  w_err_zero_nxt;
    logic               r_err_multi, w_err_multi_nxt;
    logic [CNT_W-1:0]   r_samples,   w_samples_nxt;
    logic [STB_W-1:0]   r_stable,    w_stable_nxt;

    logic               w_is_zero;
    logic               w_is_onehot;
    logic               w_is_multi;
    logic [IDX_W-1:0]   w_index;

    onehot_classify #(
        .WIDTH (WIDTH)
    ) u_classify (
        .i_vec     (a),
        .is_zero   (w_is_zero),
        .is_onehot (w_is_onehot),
        .is_multi  (w_is_multi),
        .index     (w_index)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_fin       <= 1'b0;
            r_idx       <= '0;
            r_prev_idx  <= '0;
            r_err_zero  <= 1'b0;
            r_err_multi <= 1'b0;
            r_samples   <= '0;
            r_stable    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= w_busy_nxt;
            r_fin       <= w_fin_nxt;
            r_idx       <= w_idx_nxt;
            r_prev_idx  <= w_prev_idx_nxt;
            r_err_zero  <= w_err_zero_nxt;
            r_err_multi <= w_err_multi_nxt;
            r_samples   <= w_samples_nxt;
            r_stable    <= w_stable_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_prev_idx_nxt  = r_prev_idx;
        w_err_zero_nxt  = r_err_zero;
        w_err_multi_nxt = r_err_multi;
        w_samples_nxt   = r_samples;
        w_stable_nxt    = r_stable;

        // start wins in every state, including over a same-cycle sample.
        if (start) begin
            w_state_nxt     = CHECK;
            w_prev_idx_nxt  = '0;
            w_err_zero_nxt  = 1'b0;
            w_err_multi_nxt = 1'b0;
            w_samples_nxt   = '0;
            w_stable_nxt    = '0;
        end else begin
            case (r_state)
                CHECK: begin
                    if (in_valid) begin
                        if (r_samples != '1) begin
                            w_samples_nxt = r_samples + CNT_W'(1);
                        end
                        if (w_is_onehot) begin
                            if ((w_index == r_prev_idx) && (r_stable != '0)) begin
                                w_stable_nxt = r_stable + STB_W'(1);
                            end else begin
                                w_stable_nxt = STB_W'(1);
                            end
                            w_prev_idx_nxt = w_index;
                            if (w_stable_nxt == STB_W'(STABLE)) begin
                                w_state_nxt = DONE;
                                w_idx_nxt   = w_index;
                            end
                        end else begin
                            w_stable_nxt = '0;
                            if (w_is_zero) begin
                                w_err_zero_nxt = 1'b1;
                            end
                            if (w_is_multi) begin
                                w_err_multi_nxt = 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end

        w_busy_nxt = (w_state_nxt == CHECK);
        w_fin_nxt  = (w_state_nxt == DONE);
    end

    assign busy        = r_busy;
    assign is_finished = r_fin;
    assign idx         = r_idx;
    assign err_zero    = r_err_zero;
    assign err_multi   = r_err_multi;
    assign samples     = r_samples;

endmodule

// File: tb/tb_onehot_finish_detector.sv
// Scoreboard bench: stimulus queues expected finish results, a monitor
// compares them on each rising edge of is_finished.
module tb_onehot_finish_detector;

    localparam int WIDTH  = 4;
    localparam int STABLE = 2;
    localparam int CNT_W  = 16;
    localparam int IDX_W  = 2;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic             busy;
    logic             is_finished;
    logic [IDX_W-1:0] idx;
    logic             err_zero;
    logic             err_multi;
    logic [CNT_W-1:0] samples;

    typedef struct {
        int unsigned cyc;
        logic [IDX_W-1:0] idx;
        logic ez;
        logic em;
        logic [CNT_W-1:0] samples;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc;
    int          errors;
    int          checks;
    logic        prev_fin;

    onehot_finish_detector #(
        .WIDTH  (WIDTH),
        .STABLE (STABLE),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .a           (a),
        .busy        (busy),
        .is_finished (is_finished),
        .idx         (idx),
        .err_zero    (err_zero),
        .err_multi   (err_multi),
        .samples     (samples)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic v, input logic [WIDTH-1:0] val);
        start    = s;
        in_valid = v;
        a        = val;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_finish(input logic [IDX_W-1:0] i, input logic ez,
                                 input logic em, input logic [CNT_W-1:0] n);
        exp_t e;
        e.cyc     = cyc + 1;
        e.idx     = i;
        e.ez      = ez;
        e.em      = em;
        e.samples = n;
        sb_q.push_back(e);
    endtask

    // Monitor: is_finished rising edge is the DUT's result presentation.
    initial prev_fin = 1'b0;
    always @(negedge clk) begin
        if (rst_n && is_finished && !prev_fin) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_finish", 32'(is_finished), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("finish_cycle", cyc, e.cyc);
                chk("finish_idx", 32'(idx), 32'(e.idx));
                chk("finish_err_zero", 32'(err_zero), 32'(e.ez));
                chk("finish_err_multi", 32'(err_multi), 32'(e.em));
                chk("finish_samples", 32'(samples), 32'(e.samples));
                chk("finish_busy", 32'(busy), 32'd0);
            end
        end
        prev_fin <= is_finished;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc      = 0;
        errors   = 0;
        checks   = 0;
        start    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        rst_n    = 1'b0;
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_fin", 32'(is_finished), 32'd0);
        chk("reset_idx", 32'(idx), 32'd0);
        chk("reset_samples", 32'(samples), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 0100,0100 -> idx 2
        drive(1'b1, 1'b0, 4'b0000);
        chk("start_busy", 32'(busy), 32'd1);
        drive(1'b0, 1'b1, 4'b0100);
        chk("one_sample_not_done", 32'(is_finished), 32'd0);
        expect_finish(2'd2, 1'b0, 1'b0, 16'd2);
        drive(1'b0, 1'b1, 4'b0100);
        drive(1'b0, 1'b0, 4'b0000);
        // DONE ignores further samples
        drive(1'b0, 1'b1, 4'b0010);
        drive(1'b0, 1'b1, 4'b0010);
        chk("done_hold_samples", 32'(samples), 32'd2);
        chk("done_hold_idx", 32'(idx), 32'd2);
        chk("done_hold_fin", 32'(is_finished), 32'd1);

        // 0001,0010,0010 -> idx 1
        drive(1'b1, 1'b0, 4'b0000);
        drive(1'b0, 1'b1, 4'b0001);
        drive(1'b0, 1'b1, 4'b0010);
        expect_finish(2'd1, 1'b0, 1'b0, 16'd3);
        drive(1'b0, 1'b1, 4'b0010);
        drive(1'b0, 1'b0, 4'b0000);

        // 0000,1010,1000,1000 -> idx 3 with both errors
        drive(1'b1, 1'b0, 4'b0000);
        drive(1'b0, 1'b1, 4'b0000);
        drive(1'b0, 1'b1, 4'b1010);
        drive(1'b0, 1'b1, 4'b1000);
        expect_finish(2'd3, 1'b1, 1'b1, 16'd4);
        drive(1'b0, 1'b1, 4'b1000);
        drive(1'b0, 1'b0, 4'b0000);

        // in_valid=0 gap does not break stability
        drive(1'b1, 1'b0, 4'b0000);
        drive(1'b0, 1'b1, 4'b1000);
        drive(1'b0, 1'b0, 4'b0001);
        expect_finish(2'd3, 1'b0, 1'b0, 16'd2);
        drive(1'b0, 1'b1, 4'b1000);
        drive(1'b0, 1'b0, 4'b0000);

        // restart from DONE with a same-cycle sample that must be dropped
        drive(1'b1, 1'b1, 4'b0001);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_fin", 32'(is_finished), 32'd0);
        chk("restart_samples", 32'(samples), 32'd0);
        chk("restart_err_zero", 32'(err_zero), 32'd0);
        chk("restart_idx_held", 32'(idx), 32'd3);
        drive(1'b0, 1'b1, 4'b0001);
        expect_finish(2'd0, 1'b0, 1'b0, 16'd2);
        drive(1'b0, 1'b1, 4'b0001);
        drive(1'b0, 1'b0, 4'b0000);

        // asynchronous reset mid-CHECK
        drive(1'b1, 1'b0, 4'b0000);
        drive(1'b0, 1'b1, 4'b0100);
        chk("pre_reset_samples", 32'(samples), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_fin", 32'(is_finished), 32'd0);
        chk("async_idx", 32'(idx), 32'd0);
        chk("async_samples", 32'(samples), 32'd0);
        chk("async_errs", 32'({err_zero, err_multi}), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 4'b0000);
        drive(1'b0, 1'b1, 4'b0100);
        chk("post_reset_one_sample", 32'(is_finished), 32'd0);
        expect_finish(2'd2, 1'b0, 1'b0, 16'd2);
        drive(1'b0, 1'b1, 4'b0100);
        drive(1'b0, 1'b0, 4'b0000);
        drive(1'b0, 1'b0, 4'b0000);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
